// File: rtl/tdm_demux4_if.sv
// Handshake/bus bundle for the 2-slot TDM receiver.
// The master side is the beat source plus the pair consumer. The slave side is the demux.
interface tdm_demux4_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             sync;
    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] y1;
    logic             out_valid;
    logic             out_ready;
    logic             frame_err;
    logic             overflow;

    modport master (
        output din, din_valid, sync, out_ready,
        input  y0, y1, out_valid, frame_err, overflow
    );

    modport slave (
        input  din, din_valid, sync, out_ready,
        output y0, y1, out_valid, frame_err, overflow
    );
endinterface

// File: rtl/tdm_demux4.sv
// Receive side of a 2-slot TDM bus.
// The slot 0 beat (flagged by sync) is held until the slot 1 beat arrives.
// Each slot0/slot1 pair is presented on y0/y1 behind a valid/ready handshake.
// Framing faults and dropped pairs are reported as one-cycle registered pulses.
module tdm_demux4 #(
    parameter int WIDTH        = 4,
    parameter int IDLE_TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    tdm_demux4_if.slave    bus
);
    localparam int CW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic {IDLE = 1'b0, S1 = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] c0_q, c0_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] y0_q, y0_d, y1_q, y1_d;
    logic             ov_q, ov_d;
    logic             ferr_q, ferr_d;
    logic             ovf_q, ovf_d;

    // State, capture, output and pulse registers; reset drops any partial or pending pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c0_q    <= '0;
            cnt_q   <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            ov_q    <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c0_q    <= c0_d;
            cnt_q   <= cnt_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            ov_q    <= ov_d;
            ferr_q  <= ferr_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic: frame assembly, idle timeout and output handshake.
    always_comb begin
        state_d = state_q;
        c0_d    = c0_q;
        cnt_d   = cnt_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        // A pair that is consumed this edge frees the output unless a new pair reloads it.
        ov_d    = ov_q & ~bus.out_ready;
        ferr_d  = 1'b0;
        ovf_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.din_valid) begin
                    if (bus.sync) begin
                        c0_d    = bus.din;
                        cnt_d   = '0;
                        state_d = S1;
                    end else begin
                        ferr_d = 1'b1;  // slot 1 beat with no slot 0 held
                    end
                end
            end
            S1: begin
                if (bus.din_valid) begin
                    if (bus.sync) begin
                        // A new frame start restarts the frame on this beat.
                        ferr_d = 1'b1;
                        c0_d   = bus.din;
                        cnt_d  = '0;
                    end else begin
                        state_d = IDLE;
                        if (!ov_q || bus.out_ready) begin
                            y0_d = c0_q;
                            y1_d = bus.din;
                            ov_d = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end else if (cnt_q == CW'(IDLE_TIMEOUT - 1)) begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.y0        = y0_q;
    assign bus.y1        = y1_q;
    assign bus.out_valid = ov_q;
    assign bus.frame_err = ferr_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed scenarios and then randomized traffic.
// Every cycle is compared against a frame-level reference model.
module tb_tdm_demux4;
    localparam int W  = 4;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nchk = 0;
    int   nerr = 0;

    tdm_demux4_if #(.WIDTH(W)) bus ();

    tdm_demux4 #(.WIDTH(W), .IDLE_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: an optional held slot 0 value, plus the idle cycles seen since it arrived.
    bit         m_hold;
    logic [W-1:0] m_c0;
    int         m_gap;
    logic [W-1:0] m_y0, m_y1;
    bit         m_ov, m_fe, m_of;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold = 0; m_c0 = '0; m_gap = 0;
        m_y0 = '0; m_y1 = '0; m_ov = 0; m_fe = 0; m_of = 0;
    endtask

    task automatic model_beat(input logic [W-1:0] d, input bit v, input bit s, input bit r);
        bit fe, of, nov;
        fe = 0; of = 0;
        nov = m_ov && !r;
        if (v && s) begin
            if (m_hold) fe = 1;
            m_hold = 1; m_c0 = d; m_gap = 0;
        end else if (v) begin
            if (!m_hold) fe = 1;
            else begin
                m_hold = 0;
                if (!m_ov || r) begin m_y0 = m_c0; m_y1 = d; nov = 1; end
                else of = 1;
            end
        end else if (m_hold) begin
            m_gap++;
            if (m_gap == TO) begin fe = 1; m_hold = 0; end
        end
        m_ov = nov; m_fe = fe; m_of = of;
    endtask

    task automatic cmp_all();
        check("y0",        32'(bus.y0),        32'(m_y0));
        check("y1",        32'(bus.y1),        32'(m_y1));
        check("out_valid", 32'(bus.out_valid), 32'(m_ov));
        check("frame_err", 32'(bus.frame_err), 32'(m_fe));
        check("overflow",  32'(bus.overflow),  32'(m_of));
    endtask

    // Drive one cycle of inputs, advance the model, then sample 1ns after the edge.
    task automatic step(input logic [W-1:0] d, input bit v, input bit s, input bit r);
        bus.din = d; bus.din_valid = v; bus.sync = s; bus.out_ready = r;
        model_beat(d, v, s, r);
        @(posedge clk); #1;
        cmp_all();
    endtask

    initial begin
        bus.din = '0; bus.din_valid = 0; bus.sync = 0; bus.out_ready = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_y0", 32'(bus.y0), 32'h0);
        check("reset_ov", 32'(bus.out_valid), 32'h0);
        rst_n = 1'b1;

        // Basic pair.
        step(4'hA, 1, 1, 1);
        step(4'h5, 1, 0, 1);
        check("basic_y0", 32'(bus.y0), 32'hA);
        check("basic_y1", 32'(bus.y1), 32'h5);
        step(4'h0, 0, 0, 1);
        check("basic_ov_drop", 32'(bus.out_valid), 32'h0);

        // Backpressure and overflow.
        step(4'h1, 1, 1, 0);
        step(4'h2, 1, 0, 0);
        step(4'h3, 1, 1, 0);
        step(4'h4, 1, 0, 0);
        check("bp_overflow", 32'(bus.overflow), 32'h1);
        check("bp_y0_hold", 32'(bus.y0), 32'h1);
        step(4'h0, 0, 0, 0);
        check("bp_y1_hold", 32'(bus.y1), 32'h2);
        step(4'h0, 0, 0, 1);
        check("bp_release", 32'(bus.out_valid), 32'h0);

        // Back-to-back pairs.
        step(4'h6, 1, 1, 1);
        step(4'h7, 1, 0, 1);
        step(4'h8, 1, 1, 1);
        check("b2b_gap_ov", 32'(bus.out_valid), 32'h0);
        step(4'h9, 1, 0, 1);
        check("b2b_y0", 32'(bus.y0), 32'h8);

        // Framing errors.
        step(4'h3, 1, 0, 1);
        check("frm_idle_s1", 32'(bus.frame_err), 32'h1);
        step(4'hB, 1, 1, 1);
        step(4'hC, 1, 1, 1);
        check("frm_resync", 32'(bus.frame_err), 32'h1);
        step(4'hD, 1, 0, 1);
        check("frm_y0", 32'(bus.y0), 32'hC);
        check("frm_y1", 32'(bus.y1), 32'hD);

        // Idle timeout.
        step(4'hE, 1, 1, 1);
        for (int i = 0; i < TO - 1; i++) step(4'h0, 0, 0, 1);
        check("to_early", 32'(bus.frame_err), 32'h0);
        step(4'h0, 0, 0, 1);
        check("to_fire", 32'(bus.frame_err), 32'h1);
        step(4'h2, 1, 0, 1);
        check("to_after", 32'(bus.frame_err), 32'h1);
        check("to_no_out", 32'(bus.out_valid), 32'h0);

        // Reset in S1 while a pair is pending.
        step(4'h1, 1, 1, 0);
        step(4'h2, 1, 0, 0);
        step(4'h3, 1, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_y0", 32'(bus.y0), 32'h0);
        check("rst_y1", 32'(bus.y1), 32'h0);
        check("rst_ov", 32'(bus.out_valid), 32'h0);
        check("rst_fe", 32'(bus.frame_err), 32'h0);
        check("rst_of", 32'(bus.overflow), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(4'h4, 1, 0, 1);
        check("rst_idle", 32'(bus.frame_err), 32'h1);

        // Randomized traffic across dense, medium and sparse beat phases.
        for (int i = 0; i < 3000; i++) begin
            int pv;
            logic [W-1:0] d;
            bit v, s, r;
            case ((i / 300) % 3)
                0:       pv = 85;
                1:       pv = 45;
                default: pv = 8;
            endcase
            d = W'($urandom_range(0, (1 << W) - 1));
            v = ($urandom_range(0, 99) < pv);
            s = ($urandom_range(0, 99) < 50);
            r = ($urandom_range(0, 99) < 65);
            step(d, v, s, r);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
